sram_bank_arb: RTL and testbench

//  Round-robin arbiter/sequencer that shares one sram_bank port among NUM_REQ requesters.
//  It accepts read/write commands on per-requester valid/ready and drives the bank

---
 rtl/sram_bank_arb.sv | 173 +++++++++++++++++
 tb/tb_sram_bank_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arb.sv
// sram_bank_arb
// Round-robin arbiter/sequencer sharing one sram bank port among NUM_REQ
// requesters. Writes take the bank for one cycle. Reads take it for two
// cycles: the issue cycle, then a hold cycle in which the bank's rd_data is
// captured. Read data comes back on one valid/ready response channel,
// tagged with the requester index.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req_vld/req_rdy  per-requester command handshake (req_rdy one-hot or zero)
//   req_wr           per-requester command type, 1=write 0=read
//   req_addr         packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata        packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_vld/rsp_rdy  read response handshake
//   rsp_id/rsp_data  requester index and data of the read response
//   bank_*           command/data pins of the shared sram bank
module sram_bank_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_vld,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic                           rsp_vld,
  input  logic                           rsp_rdy,
  output logic [ID_W-1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [ADDR_WIDTH-1:0]          bank_addr,
  output logic                           bank_wr_cmd_vld,
  output logic [DATA_WIDTH-1:0]          bank_wr_data,
  output logic                           bank_rd_cmd_vld,
  input  logic [DATA_WIDTH-1:0]          bank_rd_data
);

  typedef enum logic {IDLE, RD_HOLD} state_t;

  state_t                 state_reg;
  logic [ID_W-1:0]        rr_ptr_reg;
  logic [ADDR_WIDTH-1:0]  hold_addr_reg;
  logic [ID_W-1:0]        hold_id_reg;
  logic                   rsp_vld_reg;
  logic [ID_W-1:0]        rsp_id_reg;
  logic [DATA_WIDTH-1:0]  rsp_data_reg;

  // Unpacked views of the per-requester command fields.
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // A read may only be granted when the response register will be free by
  // the time the hold cycle captures into it; writes are never blocked.
  logic               rsp_busy;
  logic [NUM_REQ-1:0] eligible;

  assign rsp_busy = rsp_vld_reg & ~rsp_rdy;
  assign eligible = req_vld & ~(~req_wr & {NUM_REQ{rsp_busy}});

  // Round-robin search: scanning from the farthest offset down to offset 0
  // leaves the first eligible index at or after rr_ptr as the winner.
  logic            grant_vld;
  logic [ID_W-1:0] winner;
  int              scan_idx;

  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    scan_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (eligible[scan_idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        winner    = scan_idx[ID_W-1:0];
      end
    end
  end

  // Grants only happen in IDLE and never while reset is held, so every
  // combinational output is forced to zero during reset.
  logic grant_en;
  logic winner_wr;
  logic [ID_W-1:0] next_ptr;

  assign grant_en  = grant_vld & (state_reg == IDLE) & ~rst;
  assign winner_wr = req_wr[winner];
  assign next_ptr  = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

  always_comb begin
    req_rdy = '0;
    if (grant_en) begin
      req_rdy[winner] = 1'b1;
    end
  end

  always_comb begin
    bank_addr       = '0;
    bank_wr_cmd_vld = 1'b0;
    bank_wr_data    = '0;
    bank_rd_cmd_vld = 1'b0;
    if (!rst) begin
      if (state_reg == RD_HOLD) begin
        // Keep the read command and address on the pins so rd_data stays valid.
        bank_rd_cmd_vld = 1'b1;
        bank_addr       = hold_addr_reg;
      end else if (grant_en) begin
        bank_addr = addr_arr[winner];
        if (winner_wr) begin
          bank_wr_cmd_vld = 1'b1;
          bank_wr_data    = wdata_arr[winner];
        end else begin
          bank_rd_cmd_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      hold_addr_reg <= '0;
      hold_id_reg   <= '0;
      rsp_vld_reg   <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_en) begin
            rr_ptr_reg <= next_ptr;
            if (!winner_wr) begin
              hold_addr_reg <= addr_arr[winner];
              hold_id_reg   <= winner;
              state_reg     <= RD_HOLD;
            end
          end
        end
        RD_HOLD: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Capture in the hold cycle takes priority over a completing handshake.
      if (state_reg == RD_HOLD) begin
        rsp_vld_reg  <= 1'b1;
        rsp_id_reg   <= hold_id_reg;
        rsp_data_reg <= bank_rd_data;
      end else if (rsp_vld_reg && rsp_rdy) begin
        rsp_vld_reg <= 1'b0;
      end
    end
  end

  assign rsp_vld  = rsp_vld_reg;
  assign rsp_id   = rsp_id_reg;
  assign rsp_data = rsp_data_reg;

endmodule

// File: tb/tb_sram_bank_arb.sv
// Directed bench for sram_bank_arb with a small sram bank model and a
// scoreboard of expected read responses.
module tb_sram_bank_arb;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_vld, req_rdy, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_vld, rsp_rdy;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   bank_addr;
  logic            bank_wr_cmd_vld, bank_rd_cmd_vld;
  logic [DW-1:0]   bank_wr_data, bank_rd_data;

  logic [AW-1:0]   a_in [N];
  logic [DW-1:0]   d_in [N];

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a_in[i];
      req_wdata[i*DW +: DW] = d_in[i];
    end
  end

  sram_bank_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .bank_addr(bank_addr), .bank_wr_cmd_vld(bank_wr_cmd_vld), .bank_wr_data(bank_wr_data),
    .bank_rd_cmd_vld(bank_rd_cmd_vld), .bank_rd_data(bank_rd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hC0DE0000 | 32'(a * 3);
  endfunction

  // Bank model: rd_data appears one cycle after the read command.
  logic [DW-1:0] bank_mem [256];
  logic [DW-1:0] exp_mem  [256];

  initial bank_rd_data = '0;
  always @(posedge clk) begin
    bank_rd_data <= bank_rd_cmd_vld ? bank_mem[bank_addr] : '0;
    if (bank_wr_cmd_vld) bank_mem[bank_addr] = bank_wr_data;
  end

  // Scoreboard: expected memory follows the stimulus, reads push expected responses.
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; } rsp_t;
  rsp_t sb_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_rdy[i] && req_vld[i]) begin
          if (req_wr[i]) exp_mem[a_in[i]] = d_in[i];
          else sb_q.push_back('{id: IW'(i), data: exp_mem[a_in[i]]});
        end
      end
      if (rsp_vld && rsp_rdy) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_rsp", 64'(rsp_vld), 64'd0);
        end else begin
          rsp_t e;
          e = sb_q.pop_front();
          chk("sb_rsp_id", 64'(rsp_id), 64'(e.id));
          chk("sb_rsp_data", 64'(rsp_data), 64'(e.data));
          $display("[TB] rsp id=%0d data=0x%08h", rsp_id, rsp_data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_rdy"}, 64'(req_rdy), 64'd0);
    chk({tag, "_rsp_vld"}, 64'(rsp_vld), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_bank_addr"}, 64'(bank_addr), 64'd0);
    chk({tag, "_bank_wr"}, 64'(bank_wr_cmd_vld), 64'd0);
    chk({tag, "_bank_wdata"}, 64'(bank_wr_data), 64'd0);
    chk({tag, "_bank_rd"}, 64'(bank_rd_cmd_vld), 64'd0);
  endtask

  logic [N-1:0] fair_exp [4];
  int           req3_grants;
  logic [DW-1:0] exp3;

  initial begin
    for (int a = 0; a < 256; a++) begin
      bank_mem[a] = init_val(a);
      exp_mem[a]  = init_val(a);
    end
    bank_mem[8'h10] = 32'hDEADBEEF;
    exp_mem[8'h10]  = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) begin
      a_in[i] = AW'(8'h20 + i);
      d_in[i] = 32'h1000 + 32'(i);
    end

    // Reset with all requests asserted: every output must stay 0.
    rst = 1'b1; req_vld = 4'hF; req_wr = 4'hF; rsp_rdy = 1'b1;
    smp();
    chk_all_zero("reset");
    $display("[TB] reset state checked");
    cyc();
    rst = 1'b0;

    // Write stream: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("wr_stream_rdy", 64'(req_rdy), 64'(4'b0001 << (k % 4)));
      chk("wr_stream_cmd", 64'(bank_wr_cmd_vld), 64'd1);
      chk("wr_stream_addr", 64'(bank_addr), 64'(8'h20 + (k % 4)));
      chk("wr_stream_wdata", 64'(bank_wr_data), 64'(32'h1000 + (k % 4)));
      $display("[TB] write grant req_rdy=%b addr=0x%02h", req_rdy, bank_addr);
      cyc();
    end
    req_vld = 4'b0000;

    // Single read by requester 2 at 0x10.
    a_in[2] = 8'h10; req_wr = 4'b0000; req_vld = 4'b0100;
    smp();
    chk("rd_T_rdy", 64'(req_rdy), 64'b0100);
    chk("rd_T_rdcmd", 64'(bank_rd_cmd_vld), 64'd1);
    chk("rd_T_wrcmd", 64'(bank_wr_cmd_vld), 64'd0);
    chk("rd_T_addr", 64'(bank_addr), 64'h10);
    cyc(); req_vld = 4'b0000;
    smp();
    chk("rd_T1_rdcmd", 64'(bank_rd_cmd_vld), 64'd1);
    chk("rd_T1_addr", 64'(bank_addr), 64'h10);
    chk("rd_T1_rdy", 64'(req_rdy), 64'd0);
    chk("rd_T1_rspvld", 64'(rsp_vld), 64'd0);
    cyc(); smp();
    chk("rd_T2_rspvld", 64'(rsp_vld), 64'd1);
    chk("rd_T2_id", 64'(rsp_id), 64'd2);
    chk("rd_T2_data", 64'(rsp_data), 64'hDEADBEEF);
    $display("[TB] read req2 addr=0x10 data=0x%08h", rsp_data);

    // Backpressure: park a response from requester 3.
    cyc(); rsp_rdy = 1'b0; a_in[3] = 8'h33; req_vld = 4'b1000;
    exp3 = init_val(8'h33);
    smp();
    chk("bp_rd3_rdy", 64'(req_rdy), 64'b1000);
    cyc(); req_vld = 4'b0000;
    cyc(); smp();
    chk("bp_pending_vld", 64'(rsp_vld), 64'd1);
    chk("bp_pending_id", 64'(rsp_id), 64'd3);
    cyc();
    a_in[0] = 8'h44; a_in[1] = 8'h45; d_in[1] = 32'hCAFE0001;
    req_wr = 4'b0010; req_vld = 4'b0011;
    smp();
    chk("bp_write_wins", 64'(req_rdy), 64'b0010);
    chk("bp_write_cmd", 64'(bank_wr_cmd_vld), 64'd1);
    chk("bp_read_cmd", 64'(bank_rd_cmd_vld), 64'd0);
    chk("bp_write_addr", 64'(bank_addr), 64'h45);
    chk("bp_write_data", 64'(bank_wr_data), 64'hCAFE0001);
    chk("bp_data_hold0", 64'(rsp_data), 64'(exp3));
    $display("[TB] backpressure write req1 granted req_rdy=%b", req_rdy);
    cyc(); req_vld = 4'b0001;
    smp();
    chk("bp_read_stalled", 64'(req_rdy), 64'd0);
    chk("bp_vld_hold", 64'(rsp_vld), 64'd1);
    chk("bp_data_hold1", 64'(rsp_data), 64'(exp3));
    cyc(); rsp_rdy = 1'b1;
    smp();
    chk("bp_release_rdy", 64'(req_rdy), 64'b0001);
    chk("bp_release_rdcmd", 64'(bank_rd_cmd_vld), 64'd1);
    chk("bp_release_addr", 64'(bank_addr), 64'h44);
    chk("bp_data_hold2", 64'(rsp_data), 64'(exp3));
    cyc(); req_vld = 4'b0000;
    smp();
    chk("bp_T1_rspvld", 64'(rsp_vld), 64'd0);
    cyc(); smp();
    chk("bp_T2_rspvld", 64'(rsp_vld), 64'd1);
    chk("bp_T2_id", 64'(rsp_id), 64'd0);

    // Back-to-back reads from req0 then req1 (rr_ptr first moved to 0 by a req3 write).
    cyc(); a_in[3] = 8'h70; d_in[3] = 32'h77; req_wr = 4'b1000; req_vld = 4'b1000;
    smp();
    chk("b2b_prep_rdy", 64'(req_rdy), 64'b1000);
    cyc(); a_in[0] = 8'h21; a_in[1] = 8'h10; req_wr = 4'b0000; req_vld = 4'b0011;
    smp();
    chk("b2b_T_rdy", 64'(req_rdy), 64'b0001);
    cyc(); req_vld = 4'b0010;
    smp();
    chk("b2b_T1_rdy", 64'(req_rdy), 64'd0);
    cyc(); smp();
    chk("b2b_T2_rdy", 64'(req_rdy), 64'b0010);
    chk("b2b_T2_vld", 64'(rsp_vld), 64'd1);
    chk("b2b_T2_id", 64'(rsp_id), 64'd0);
    chk("b2b_T2_data", 64'(rsp_data), 64'h1001);
    cyc(); req_vld = 4'b0000;
    smp();
    chk("b2b_T3_vld", 64'(rsp_vld), 64'd0);
    cyc(); smp();
    chk("b2b_T4_vld", 64'(rsp_vld), 64'd1);
    chk("b2b_T4_id", 64'(rsp_id), 64'd1);
    chk("b2b_T4_data", 64'(rsp_data), 64'hDEADBEEF);

    // Fairness: req0 and req3 both always valid; pointer starts at 2.
    fair_exp[0] = 4'b1000; fair_exp[1] = 4'b0001;
    fair_exp[2] = 4'b1000; fair_exp[3] = 4'b0001;
    req3_grants = 0;
    cyc(); a_in[0] = 8'h80; a_in[3] = 8'h83; req_wr = 4'b1001; req_vld = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("fair_rdy", 64'(req_rdy), 64'(fair_exp[k]));
      if (req_rdy[3]) req3_grants++;
      $display("[TB] fairness grant req_rdy=%b", req_rdy);
      cyc();
    end
    chk("fair_req3_count", 64'(req3_grants), 64'd2);
    req_vld = 4'b0000;

    // Reset in the middle of a read hold cycle: the read is dropped.
    a_in[0] = 8'h60; req_wr = 4'b0000; req_vld = 4'b0001;
    smp();
    chk("rstmid_grant", 64'(req_rdy), 64'b0001);
    cyc(); req_vld = 4'b0000;
    smp();
    chk("rstmid_hold", 64'(bank_rd_cmd_vld), 64'd1);
    #2;
    rst = 1'b1; req_vld = 4'hF; req_wr = 4'hF;
    #1;
    chk_all_zero("rstmid");
    sb_q.delete();
    cyc(); cyc();
    rst = 1'b0;
    smp();
    chk("rstmid_first_grant", 64'(req_rdy), 64'b0001);
    chk("rstmid_no_rsp0", 64'(rsp_vld), 64'd0);
    $display("[TB] post-reset grant req_rdy=%b", req_rdy);
    cyc(); req_vld = 4'b0000;
    smp();
    chk("rstmid_no_rsp1", 64'(rsp_vld), 64'd0);
    cyc(); smp();
    chk("rstmid_no_rsp2", 64'(rsp_vld), 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
